// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between a synchronous instruction memory
// and decode. Tracks a fetch PC, one outstanding read, and DEPTH {instr, pc} entries.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brz,
  input  logic        brn,
  input  logic        j,
  input  logic        zero,
  input  logic        neg,
  input  logic [31:0] rd1,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          taken;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;

  // Outstanding read counts against capacity so a returning word always has a slot.
  assign taken     = j | (brz & zero) | (brn & neg);
  assign occ       = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign imem_req  = !rst && !taken && (occ < (CW + 1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign push      = inflight_q & !taken;
  assign pop       = out_valid & out_ready & !taken;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (taken) begin
      // Redirect wins over everything: drop queue contents and the in-flight word.
      fetch_pc_d = rd1;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd1;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized plus directed stimulus for fetch_queue, checked by a
// scoreboard of fetched-but-undelivered PCs that is flushed on every taken branch.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        brz, brn, j, zero, neg;
  logic [31:0] rd1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int passes = 0;

  // Scoreboard: PCs requested since the last flush and not yet handed to decode.
  logic [31:0] sbq[$];
  logic [31:0] modelPc;
  bit          lastReq;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .brz       (brz),
    .brn       (brn),
    .j         (j),
    .zero      (zero),
    .neg       (neg),
    .rd1       (rd1),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_data (imem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: word at address a holds 0x1000 + a.
  always @(posedge clk) begin
    if (imem_req) imem_data <= imem_addr + 32'h1000;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare DUT against the scoreboard mid-cycle, then advance the model
  // to what the coming rising edge should produce.
  always @(negedge clk) begin
    bit          takenM;
    bit          expValid;
    bit          expReq;
    if (rst) begin
      checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_imem_addr", imem_addr, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_pc", out_pc, 32'd0);
      sbq.delete();
      modelPc = 32'd0;
      lastReq = 1'b0;
    end else begin
      takenM   = j | (brz & zero) | (brn & neg);
      expValid = (sbq.size() - int'(lastReq)) > 0;
      expReq   = !takenM && (sbq.size() < DEPTH);
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, expReq});
      checkOutput("imem_addr", imem_addr, modelPc);
      if (expValid) begin
        checkOutput("out_pc", out_pc, sbq[0]);
        checkOutput("out_instr", out_instr, sbq[0] + 32'h1000);
      end else begin
        checkOutput("out_pc_empty", out_pc, 32'd0);
        checkOutput("out_instr_empty", out_instr, 32'd0);
      end
      if (takenM) begin
        sbq.delete();
        modelPc = rd1;
        lastReq = 1'b0;
      end else begin
        if (expValid && out_ready) void'(sbq.pop_front());
        if (expReq) begin
          sbq.push_back(modelPc);
          modelPc = modelPc + 32'd1;
        end
        lastReq = expReq;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rdy, input logic bz, input logic bn,
                               input logic jj, input logic z, input logic n,
                               input logic [31:0] target);
    out_ready = rdy;
    brz = bz; brn = bn; j = jj; zero = z; neg = n;
    rd1 = target;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input logic rdy, input int n);
    for (int k = 0; k < n; k++) applyStimulus(rdy, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    brz = 0; brn = 0; j = 0; zero = 0; neg = 0;
    rd1 = 32'd0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;

    idleCycles(1, 10);                               // streaming
    idleCycles(0, 10);                               // backpressure fills the queue
    idleCycles(1, 6);                                // release
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h40);         // jump
    idleCycles(1, 5);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h200);        // brz not taken
    idleCycles(1, 3);
    applyStimulus(1, 1, 0, 0, 1, 0, 32'h300);        // brz taken
    idleCycles(1, 3);
    applyStimulus(1, 0, 1, 0, 0, 1, 32'h400);        // brn taken
    idleCycles(0, 6);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h500);        // redirect on a full queue, pop ignored
    idleCycles(1, 4);
    for (int k = 0; k < 3 * DEPTH * 2; k++)          // ready toggling across pointer wrap
      applyStimulus(k[0], 0, 0, 0, 0, 0, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);  // fetch PC wrap
    idleCycles(1, 5);

    idleCycles(0, 6);                                // asynchronous reset with a full queue
    #2 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("async_out_pc", out_pc, 32'd0);
    checkOutput("async_imem_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idleCycles(1, 5);

    for (int k = 0; k < 400; k++) begin              // randomized mix
      int r;
      r = $urandom_range(0, 19);
      applyStimulus($urandom_range(0, 3) != 0, r == 0, r == 1, r == 2,
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
    end
    idleCycles(1, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
